// File: rtl/display_resultado.sv
// Double-dabble converter from the multiplier product to six active-low seven-segment displays.
// Define DISPLAY_SIGNED_EN to treat the product as two's complement with a sign on display 5.
`timescale 1ns/1ps
module display_resultado #(
    parameter bit SUPRIMIR_CEROS = 1'b1
) (
    input  logic        reloj,
    input  logic        reinicio,
    input  logic [15:0] resultado,
    input  logic        valido,
    output logic        ocupado,
    output logic        listo,
    output logic [6:0]  sieteSegmentos0,
    output logic [6:0]  sieteSegmentos1,
    output logic [6:0]  sieteSegmentos2,
    output logic [6:0]  sieteSegmentos3,
    output logic [6:0]  sieteSegmentos4,
    output logic [6:0]  sieteSegmentos5
);

    localparam int unsigned ANCHO_BIN = 16;
    localparam int unsigned DIGITOS   = 5;
    localparam int unsigned ANCHO_BCD = 4 * DIGITOS;
    localparam int unsigned ANCHO_CTA = 4;
    localparam logic [6:0] SEG_BLANCO = 7'b1111111;
    localparam logic [6:0] SEG_MENOS  = 7'b0111111;
    localparam logic [6:0] SEG_CERO   = 7'b1000000;

    typedef enum logic [1:0] {REPOSO, DESPLAZA, ACTUALIZA} estado_t;

    estado_t              estado, estadoSig;
    logic [ANCHO_BIN-1:0] binario, binarioSig, pendValor, pendValorSig, operando;
    logic [ANCHO_BCD-1:0] bcd, bcdSig, bcdAjustado;
    logic [ANCHO_CTA-1:0] cuenta, cuentaSig;
    logic                 pendiente, pendienteSig;
    logic                 cargar, actualizar, ocupadoSig, listoSig;
    logic                 negativo, ceroArriba;
    logic [DIGITOS-1:0]   blanco;
    logic [6:0]           segDigito [DIGITOS];

    function automatic logic [6:0] segmento(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANCO;
        endcase
    endfunction

    function automatic logic [ANCHO_BIN-1:0] magnitud(input logic [ANCHO_BIN-1:0] v);
`ifdef DISPLAY_SIGNED_EN
        return v[ANCHO_BIN-1] ? 16'(~v + 16'd1) : v;
`else
        return v;
`endif
    endfunction

    // Next-state and datapath: one shift-add-3 step per DESPLAZA cycle
    always_comb begin
        estadoSig    = estado;
        binarioSig   = binario;
        bcdSig       = bcd;
        cuentaSig    = cuenta;
        pendienteSig = pendiente;
        pendValorSig = pendValor;
        cargar       = 1'b0;
        actualizar   = 1'b0;
        listoSig     = 1'b0;
        operando     = resultado;
        bcdAjustado  = bcd;
        for (int i = 0; i < DIGITOS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcdAjustado[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end

        case (estado)
            REPOSO: begin
                if (valido) cargar = 1'b1;
            end
            DESPLAZA: begin
                {bcdSig, binarioSig} = {bcdAjustado, binario} << 1;
                cuentaSig = cuenta + 4'd1;
                if (cuenta == 4'd15) estadoSig = ACTUALIZA;
                if (valido) begin
                    pendienteSig = 1'b1;
                    pendValorSig = resultado;
                end
            end
            ACTUALIZA: begin
                actualizar = 1'b1;
                listoSig   = 1'b1;
                if (valido) begin
                    cargar       = 1'b1;
                    pendienteSig = 1'b0;
                end else if (pendiente) begin
                    cargar       = 1'b1;
                    operando     = pendValor;
                    pendienteSig = 1'b0;
                end else begin
                    estadoSig = REPOSO;
                end
            end
            default: estadoSig = REPOSO;
        endcase

        if (cargar) begin
            binarioSig = magnitud(operando);
            bcdSig     = '0;
            cuentaSig  = '0;
            estadoSig  = DESPLAZA;
        end
        ocupadoSig = (estadoSig != REPOSO);
    end

    // Leading-zero blanking of digits 4..1; digit 0 always shown
    always_comb begin
        ceroArriba = 1'b1;
        blanco     = '0;
        for (int k = DIGITOS - 1; k >= 1; k--) begin
            ceroArriba = ceroArriba & (bcd[4*k +: 4] == 4'd0);
            blanco[k]  = SUPRIMIR_CEROS & ceroArriba;
        end
        for (int k = 0; k < DIGITOS; k++)
            segDigito[k] = blanco[k] ? SEG_BLANCO : segmento(bcd[4*k +: 4]);
    end

    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            estado          <= REPOSO;
            binario         <= '0;
            bcd             <= '0;
            cuenta          <= '0;
            pendiente       <= 1'b0;
            pendValor       <= '0;
            ocupado         <= 1'b0;
            listo           <= 1'b0;
            sieteSegmentos0 <= SEG_CERO;
            sieteSegmentos1 <= SEG_BLANCO;
            sieteSegmentos2 <= SEG_BLANCO;
            sieteSegmentos3 <= SEG_BLANCO;
            sieteSegmentos4 <= SEG_BLANCO;
            sieteSegmentos5 <= SEG_BLANCO;
        end else begin
            estado    <= estadoSig;
            binario   <= binarioSig;
            bcd       <= bcdSig;
            cuenta    <= cuentaSig;
            pendiente <= pendienteSig;
            pendValor <= pendValorSig;
            ocupado   <= ocupadoSig;
            listo     <= listoSig;
            if (actualizar) begin
                sieteSegmentos0 <= segDigito[0];
                sieteSegmentos1 <= segDigito[1];
                sieteSegmentos2 <= segDigito[2];
                sieteSegmentos3 <= segDigito[3];
                sieteSegmentos4 <= segDigito[4];
                sieteSegmentos5 <= negativo ? SEG_MENOS : SEG_BLANCO;
            end
        end
    end

`ifdef DISPLAY_SIGNED_EN
    // Sign is latched with the operand so a later pending strobe cannot disturb it
    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio)   negativo <= 1'b0;
        else if (cargar) negativo <= operando[ANCHO_BIN-1];
    end
`else
    assign negativo = 1'b0;
`endif

endmodule

// File: doc/display_resultado.md
# display_resultado

Sequential converter that reads the 16-bit product emitted by the multiplier and drives six active-low seven-segment displays. On each `valido` strobe it captures the product, converts it to five BCD digits by a 16-step shift-add-3 (double-dabble) sequence, and updates all six displays together. Display 5 carries the sign. The block sits between the multiplier output and the board's HEX0–HEX5 pins in the top level.

## Interface
- `SUPRIMIR_CEROS`, 1: 1 = blank leading zeros in displays 4..1; 0 = always show five digits.
- `reloj` in 1: single clock, rising edge.
- `reinicio` in 1: asynchronous, active-low reset.
- `resultado` in 16: product from the multiplier.
- `valido` in 1: one-cycle strobe; `resultado` is valid in the same cycle.
- `ocupado` out 1: conversion in progress.
- `listo` out 1: one-cycle pulse when the displays update.
- `sieteSegmentos0`..`sieteSegmentos5` out 7 each: active-low segments, bit6 = g … bit0 = a. Display 0 is the units digit.

## Operation
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111, minus = 0111111
- FSM states:
  - REPOSO: idle. If `valido`, capture the magnitude into the shift register and the sign into `negativo`, clear the BCD accumulator (20 bits), clear the counter, and go to DESPLAZA.
  - DESPLAZA: each cycle, add 3 to every BCD nibble ≥ 5, then shift {BCD, binary} left by 1. After 16 shifts, go to ACTUALIZA.
  - ACTUALIZA: load all six display registers from BCD plus sign, pulse `listo`. Then go to DESPLAZA (loading the pending operand) if a request is pending; otherwise go to REPOSO.
- Pending request:
  - `valido` while not in REPOSO stores `resultado` in a one-deep pending register and sets `pendiente`.
  - A later strobe overwrites the earlier pending value (last wins).
  - A strobe in the ACTUALIZA cycle itself is used directly as the next operand.
- Display mapping:
  - Digits 4..0 go to displays 4..0.
  - With `SUPRIMIR_CEROS` = 1, a digit is blanked when it and all higher digits are zero. Display 0 is never blanked.
  - Display 5 shows minus when `negativo`, blank otherwise.
- Displays hold their value between updates and never show intermediate conversion state.

## Timing
- Reset (asynchronous, `reinicio` = 0):
  - state REPOSO; `ocupado` = 0, `listo` = 0, `pendiente` = 0.
  - display 0 = 1000000 ("0"); displays 1–5 = 1111111.
- `valido` sampled at edge N:
  - `ocupado` = 1 after edge N.
  - 16 shifts occur on edges N+1..N+16.
  - At edge N+17, the displays update and `listo` = 1 for exactly one cycle.
  - After edge N+17, `ocupado` = 0 unless a pending conversion starts.
  - Latency: 17 cycles; throughput: one conversion per 17 cycles.
- Back-to-back: with a pending request, the next conversion's first shift happens at edge N+18, and `ocupado` stays high continuously.
- Reset mid-conversion: the conversion is aborted, the pending request is discarded, and the displays return to their reset values immediately.
- `valido` held high continuously: behaves as repeated strobes. Each ACTUALIZA picks up the current `resultado`, with no stall.

## Configuration
- `DISPLAY_SIGNED_EN` defined:
  - `resultado` is two's complement; magnitude = −`resultado` when bit15 = 1.
  - −32768 gives magnitude 32768.
  - `negativo` = bit15.
- Not defined:
  - `resultado` is unsigned (0..65535).
  - `negativo` is tied to 0, so display 5 is always blank.
  - The negation logic is not synthesized.

## Test plan
- Reset, then release with no strobe -> display 0 = 1000000, displays 1–5 = 1111111, `ocupado` = 0, `listo` never asserts.
- Signed, `resultado` = 16'hC080 (−16256), one strobe -> after 17 cycles, displays 5..0 = minus,1,6,2,5,6; one `listo` pulse.
- `SUPRIMIR_CEROS` = 1, `resultado` = 7 -> display 0 = 1111000, displays 1–5 blank. With `SUPRIMIR_CEROS` = 0 -> displays 4..1 = 1000000.
- Unsigned build, `resultado` = 16'hFFFF -> displays 4..0 = 6,5,5,3,5, display 5 blank. Signed build, same input -> minus, then display 0 = 1 with displays 4..1 blank.
- Strobe 100, then at +3 cycles strobe 200, at +5 cycles strobe 300 -> exactly two `listo` pulses, 17 cycles apart, showing 100 then 300; `ocupado` continuous.
- Strobe 1234, assert `reinicio` at cycle +9 -> displays go to reset values at once, no `listo`, and the next strobe of 42 converts normally.
